pll_lock_supervisor: RTL and testbench

- Parametrised clock/reset supervisor for a rPLL-based clock tree; runs on the always-present reference clock (27 MHz on board).
- Drives PLL reset, qualifies the PLL lock signal, and releases per-domain resets in a fixed order.
- Retries lock with timeout, reports failure, and counts lock losses.
- Sits between the PLL primitive wrapper and every clock domain derived from it (pixel, TMDS, ...).

---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/pll_lock_supervisor_sync.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 211 +++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and helpers for the PLL lock supervisor.
//   pll_state_e  - supervisor FSM state encoding (also exported on state_o)
//   LOSS_CNT_W   - width of the saturating lock-loss counter
//   cnt_w()      - bits needed to hold a counter value 0..max_val
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } pll_state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// sync_2ff: two-flop synchroniser for a single level signal.
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops
//   d   - asynchronous input level
//   q   - synchronised level, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, qualifies PLL lock and releases
// downstream domain resets in index order. Runs on the reference clock.
//
// Ports:
//   clkin             - reference clock
//   reset             - synchronous active-high reset
//   pll_lock_in       - raw PLL LOCK, asynchronous to clkin
//   pll_reset_o       - PLL reset (active-high)
//   domain_rst_o      - per-domain resets (active-high), index 0 released first
//   all_ready_o       - high only while in RUN
//   fail_o            - sticky failure flag, cleared only by reset
//   lock_loss_count_o - saturating count of lock losses seen in RUN
//   state_o           - current FSM state (pll_state_e encoding), for debug
//
// There are no valid/ready handshakes here: pll_lock_in is a level that is
// synchronised internally and every output is a registered level.
//
// Optional build macro PLL_SUP_GLITCH_FILTER_EN: when defined, a loss in RUN
// is declared only after GLITCH_CYCLES consecutive low lock samples.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_DOMAINS         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int RELEASE_GAP_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3,
  parameter int GLITCH_CYCLES       = 4
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   pll_lock_in,
  output logic                   pll_reset_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic                   all_ready_o,
  output logic                   fail_o,
  output logic [LOSS_CNT_W-1:0]  lock_loss_count_o,
  output logic [2:0]             state_o
);

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || GLITCH_CYCLES < 1) begin : g_param_check
    $error("pll_lock_supervisor: parameter out of range");
  end

  localparam int REL_MAX = RELEASE_GAP_CYCLES * NUM_DOMAINS;
  localparam int RST_W   = cnt_w(PLL_RST_CYCLES);
  localparam int TO_W    = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int STB_W   = cnt_w(LOCK_STABLE_CYCLES);
  localparam int REL_W   = cnt_w(REL_MAX);
  localparam int RTY_W   = cnt_w(MAX_RETRIES);

  // Each counter starts at 0 on state entry, so the last cycle of a phase of
  // length N is the one where the counter reads N-1.
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_END  = REL_W'(REL_MAX);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  pll_state_e       state;
  logic             lock_s;
  logic [RST_W-1:0] rst_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [STB_W-1:0] stab_cnt;
  logic [REL_W-1:0] rel_cnt;
  logic [REL_W-1:0] rel_nxt;
  logic [RTY_W-1:0] retry_cnt;
  logic [RTY_W-1:0] retry_nxt;
  logic             run_loss;

  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock_in),
    .q   (lock_s)
  );

  assign rel_nxt   = rel_cnt + 1'b1;
  assign retry_nxt = retry_cnt + 1'b1;
  assign state_o   = state;

`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam int GL_W = cnt_w(GLITCH_CYCLES);
  localparam logic [GL_W-1:0] GL_FULL = GL_W'(GLITCH_CYCLES);
  logic [GL_W-1:0] glitch_cnt;
  // Loss is acted on the cycle after the filter fills.
  assign run_loss = (glitch_cnt == GL_FULL);
`else
  assign run_loss = ~lock_s;
`endif

  always_ff @(posedge clkin) begin
    if (reset) begin
      state             <= PLL_RST;
      pll_reset_o       <= 1'b1;
      domain_rst_o      <= '1;
      all_ready_o       <= 1'b0;
      fail_o            <= 1'b0;
      lock_loss_count_o <= '0;
      retry_cnt         <= '0;
      rst_cnt           <= '0;
      to_cnt            <= '0;
      stab_cnt          <= '0;
      rel_cnt           <= '0;
`ifdef PLL_SUP_GLITCH_FILTER_EN
      glitch_cnt        <= '0;
`endif
    end else begin
      case (state)
        PLL_RST: begin
          if (rst_cnt == RST_LAST) begin
            state       <= WAIT_LOCK;
            pll_reset_o <= 1'b0;
            to_cnt      <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state    <= STABLE;
            stab_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            retry_cnt   <= retry_nxt;
            pll_reset_o <= 1'b1;
            if (retry_nxt == RTY_MAX) begin
              state  <= FAIL;
              fail_o <= 1'b1;
            end else begin
              state   <= PLL_RST;
              rst_cnt <= '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state  <= WAIT_LOCK;
            to_cnt <= '0;
          end else if (stab_cnt == STB_LAST) begin
            state   <= RELEASE;
            rel_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (!lock_s) begin
            state        <= WAIT_LOCK;
            domain_rst_o <= '1;
            to_cnt       <= '0;
          end else if (rel_cnt == REL_END) begin
            state       <= RUN;
            all_ready_o <= 1'b1;
            retry_cnt   <= '0;
`ifdef PLL_SUP_GLITCH_FILTER_EN
            glitch_cnt  <= '0;
`endif
          end else begin
            rel_cnt <= rel_nxt;
            // Domain i drops when the cycle count since entry hits GAP*(i+1).
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (rel_nxt == REL_W'(RELEASE_GAP_CYCLES * (i + 1))) begin
                domain_rst_o[i] <= 1'b0;
              end
            end
          end
        end

        RUN: begin
          retry_cnt <= '0;
          if (run_loss) begin
            state        <= PLL_RST;
            pll_reset_o  <= 1'b1;
            domain_rst_o <= '1;
            all_ready_o  <= 1'b0;
            rst_cnt      <= '0;
            if (lock_loss_count_o != {LOSS_CNT_W{1'b1}}) begin
              lock_loss_count_o <= lock_loss_count_o + 1'b1;
            end
          end else begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
            glitch_cnt <= lock_s ? '0 : glitch_cnt + 1'b1;
`endif
          end
        end

        FAIL: begin
          pll_reset_o  <= 1'b1;
          domain_rst_o <= '1;
          all_ready_o  <= 1'b0;
          fail_o       <= 1'b1;
        end

        default: begin
          state        <= PLL_RST;
          pll_reset_o  <= 1'b1;
          domain_rst_o <= '1;
          all_ready_o  <= 1'b0;
          rst_cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int N    = 3;
  localparam int STB  = 8;
  localparam int TO   = 32;
  localparam int PRC  = 4;
  localparam int GAP  = 2;
  localparam int MR   = 2;
  localparam int GL   = 4;
  localparam int REL_LEN = GAP * N + 1;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STB  = 3'd2;
  localparam logic [2:0] S_REL  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_FAIL = 3'd5;

`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam int LOSS_LAT  = 2 + GL + 1;
  localparam int TRIG_DROP = 5;
`else
  localparam int LOSS_LAT  = 3;
  localparam int TRIG_DROP = 3;
`endif

  localparam logic [16:0] RST_VEC = {S_RST, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0};

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         pll_lock_in;
  logic         pll_reset_o;
  logic [N-1:0] domain_rst_o;
  logic         all_ready_o;
  logic         fail_o;
  logic [7:0]   lock_loss_count_o;
  logic [2:0]   state_o;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .NUM_DOMAINS         (N),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TO),
    .PLL_RST_CYCLES      (PRC),
    .RELEASE_GAP_CYCLES  (GAP),
    .MAX_RETRIES         (MR),
    .GLITCH_CYCLES       (GL)
  ) dut (
    .clkin             (clk),
    .reset             (reset),
    .pll_lock_in       (pll_lock_in),
    .pll_reset_o       (pll_reset_o),
    .domain_rst_o      (domain_rst_o),
    .all_ready_o       (all_ready_o),
    .fail_o            (fail_o),
    .lock_loss_count_o (lock_loss_count_o),
    .state_o           (state_o)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [16:0] exp_q[$];
  bit          lock_q[$];

  function automatic logic [16:0] obs();
    return {state_o, pll_reset_o, domain_rst_o, all_ready_o, fail_o, lock_loss_count_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One reset edge; afterwards we sit at cycle 0 with reset released.
  task automatic do_reset(input bit lock_level);
    reset       = 1'b1;
    pll_lock_in = lock_level;
    tick();
    check("reset_state", obs(), RST_VEC);
    reset = 1'b0;
    exp_q.delete();
    lock_q.delete();
    cyc = 0;
  endtask

  // Expected outputs follow directly from the state being shown.
  task automatic push_phase(input logic [2:0] st, input int n, input logic [7:0] cnt);
    logic       pll, rdy, fl;
    logic [2:0] dom;
    pll = (st == S_RST) || (st == S_FAIL);
    rdy = (st == S_RUN);
    fl  = (st == S_FAIL);
    dom = rdy ? 3'b000 : 3'b111;
    for (int k = 0; k < n; k++) exp_q.push_back({st, pll, dom, rdy, fl, cnt});
  endtask

  // Domain i is released GAP*(i+1) cycles after RELEASE entry.
  task automatic push_release(input logic [7:0] cnt);
    logic [2:0] dom;
    for (int j = 0; j < REL_LEN; j++) begin
      for (int i = 0; i < N; i++) dom[i] = (j >= GAP * (i + 1)) ? 1'b0 : 1'b1;
      exp_q.push_back({S_REL, 1'b0, dom, 1'b0, 1'b0, cnt});
    end
  endtask

  task automatic push_lock(input bit v, input int n);
    for (int k = 0; k < n; k++) lock_q.push_back(v);
  endtask

  task automatic fill_lock(input bit v);
    while (lock_q.size() < exp_q.size()) lock_q.push_back(v);
  endtask

  // Lock rises after cycle L; the FSM sees it 3 cycles later but cannot
  // leave PLL_RST before cycle 4, so STABLE starts at max(L+3, 5).
  task automatic plan_bringup(input int L, input int run_n, input logic [7:0] cnt);
    int s;
    s = (L + 3 > PRC + 1) ? L + 3 : PRC + 1;
    push_phase(S_RST, PRC, cnt);
    push_phase(S_WAIT, s - PRC, cnt);
    push_phase(S_STB, STB, cnt);
    push_release(cnt);
    push_phase(S_RUN, run_n, cnt);
    push_lock(1'b0, L);
    fill_lock(1'b1);
  endtask

  // Lock falls for d cycles at the current end of the plan (in RUN).
  task automatic plan_loss(input int d, input logic [7:0] cnt_before);
    logic [7:0] c1;
    c1 = (cnt_before == 8'hFF) ? 8'hFF : cnt_before + 8'd1;
    push_phase(S_RUN, LOSS_LAT, cnt_before);
    push_phase(S_RST, PRC, c1);
    push_phase(S_WAIT, 1, c1);
    push_phase(S_STB, STB, c1);
    push_release(c1);
    push_phase(S_RUN, 5, c1);
    push_lock(1'b0, d);
    fill_lock(1'b1);
  endtask

  task automatic run_trace(input int n);
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      check("trace", obs(), exp_q.pop_front());
      pll_lock_in = lock_q.pop_front();
      tick();
    end
  endtask

  task automatic wait_ready(input logic val, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (all_ready_o === val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- directed steps ----------------
  initial begin
    int L, d, r;
    bit ok;
    reset       = 1'b1;
    pll_lock_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clean bring-up, lock at cycle 10.
    do_reset(1'b0);
    plan_bringup(10, 6, 8'd0);
    run_trace(1000);

    // Bring-ups with random lock arrival.
    for (int t = 0; t < 3; t++) begin
      do_reset(1'b0);
      L = $urandom_range(0, 30);
      plan_bringup(L, 4, 8'd0);
      run_trace(1000);
    end

    // No lock ever: two pulses and two timeouts, then FAIL, deaf to lock.
    do_reset(1'b0);
    push_phase(S_RST, PRC, 8'd0);
    push_phase(S_WAIT, TO, 8'd0);
    push_phase(S_RST, PRC, 8'd0);
    push_phase(S_WAIT, TO, 8'd0);
    push_phase(S_FAIL, 20, 8'd0);
    push_lock(1'b0, 2 * (PRC + TO));
    for (int k = 0; k < 20; k++) lock_q.push_back(1'($urandom_range(0, 1)));
    run_trace(1000);

    // One-cycle lock drop after d stable cycles restarts qualification.
    for (int t = 0; t < 3; t++) begin
      do_reset(1'b0);
      L = $urandom_range(2, 20);
      d = (t == 0) ? 5 : $urandom_range(1, 7);
      push_phase(S_RST, PRC, 8'd0);
      push_phase(S_WAIT, L + 3 - PRC, 8'd0);
      push_phase(S_STB, d + 1, 8'd0);
      push_phase(S_WAIT, 1, 8'd0);
      push_phase(S_STB, STB, 8'd0);
      push_release(8'd0);
      push_phase(S_RUN, 5, 8'd0);
      push_lock(1'b0, L);
      push_lock(1'b1, d + 1);
      push_lock(1'b0, 1);
      fill_lock(1'b1);
      run_trace(1000);
    end

    // Loss in RUN.
    do_reset(1'b0);
    L = $urandom_range(0, 20);
    r = $urandom_range(2, 10);
    plan_bringup(L, r, 8'd0);
`ifdef PLL_SUP_GLITCH_FILTER_EN
    plan_loss(TRIG_DROP, 8'd0);
    // A 3-cycle drop must be filtered out.
    push_phase(S_RUN, 12, 8'd1);
    push_lock(1'b0, 3);
    fill_lock(1'b1);
`else
    plan_loss(3, 8'd0);
    plan_loss($urandom_range(1, 3), 8'd1);
`endif
    run_trace(1000);

    // Reset between domain 0 and domain 1 release.
    do_reset(1'b0);
    plan_bringup(10, 5, 8'd0);
    run_trace(13 + STB + GAP + 1);
    check("mid_rel_dom_pre", 32'(domain_rst_o), 32'(3'b110));
    reset = 1'b1;
    tick();
    check("mid_rel_reset", obs(), RST_VEC);
    check("mid_rel_state", 32'(state_o), 32'(S_RST));
    reset = 1'b0;
    exp_q.delete();
    lock_q.delete();
    cyc = 0;
    plan_bringup(0, 5, 8'd0);
    run_trace(1000);

    // Saturation of the loss counter.
    do_reset(1'b0);
    plan_bringup(0, 2, 8'd0);
    run_trace(1000);
    for (int i = 1; i <= 260; i++) begin
      pll_lock_in = 1'b0;
      repeat (TRIG_DROP) tick();
      pll_lock_in = 1'b1;
      wait_ready(1'b0, ok);
      check("sat_loss_seen", 32'(ok), 32'd1);
      wait_ready(1'b1, ok);
      check("sat_recover", 32'(ok), 32'd1);
      check("sat_count", 32'(lock_loss_count_o), (i > 255) ? 32'd255 : 32'(i));
    end
    check("sat_final_state", 32'(state_o), 32'(S_RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
